// File: rtl/flp_pkg.sv
// Shared FLP/NLP timing constants and types for the 10BASE-T link pulse
// transmitter and receiver.
package flp_pkg;

    localparam int unsigned FLP_PW_MIN   = 5;
    localparam int unsigned FLP_DATA_MIN = 5550;
    localparam int unsigned FLP_DATA_MAX = 6950;
    localparam int unsigned FLP_CLK_MIN  = 11100;
    localparam int unsigned FLP_CLK_MAX  = 13900;
    localparam int unsigned FLP_LINK_TO  = 5000000;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    typedef struct packed {
        logic       np;
        logic       ack;
        logic       rf;
        logic [7:0] ability;
        logic [4:0] selector;
    } code_word_t;

endpackage

// File: rtl/flp_pulse_det.sv
// Receive-pair synchronizer and run-length qualifier: emits one pulse event
// per differential pulse that stays high for at least PW_MIN cycles.
module flp_pulse_det
    import flp_pkg::*;
#(
    parameter int unsigned PW_MIN = FLP_PW_MIN
) (
    input  logic clk,
    input  logic reset,
    input  logic rxp,
    input  logic rxn,
    output logic pulse
);

    localparam int unsigned RW = $clog2(PW_MIN + 1);
    localparam logic [RW-1:0] RUN_SAT  = RW'(PW_MIN);
    localparam logic [RW-1:0] RUN_FIRE = RW'(PW_MIN - 1);

    logic [1:0]    rxp_sync;
    logic [1:0]    rxn_sync;
    logic [RW-1:0] run;
    logic          hi;

    assign hi = rxp_sync[1] & ~rxn_sync[1];

    // Saturating run counter; the event fires on the step into saturation only.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxp_sync <= '0;
            rxn_sync <= '0;
            run      <= '0;
            pulse    <= 1'b0;
        end else begin
            rxp_sync <= {rxp_sync[0], rxp};
            rxn_sync <= {rxn_sync[0], rxn};
            pulse    <= hi && (run == RUN_FIRE);
            if (!hi) begin
                run <= '0;
            end else if (run != RUN_SAT) begin
                run <= run + RW'(1);
            end
        end
    end

endmodule

// File: rtl/flp_rx.sv
// Link pulse receiver: classifies NLPs and FLP bursts, decodes the 16-bit
// link code word and maintains the link-integrity flag.
module flp_rx
    import flp_pkg::*;
#(
    parameter int unsigned PW_MIN   = FLP_PW_MIN,
    parameter int unsigned DATA_MIN = FLP_DATA_MIN,
    parameter int unsigned DATA_MAX = FLP_DATA_MAX,
    parameter int unsigned CLK_MIN  = FLP_CLK_MIN,
    parameter int unsigned CLK_MAX  = FLP_CLK_MAX,
    parameter int unsigned LINK_TO  = FLP_LINK_TO
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Rxp,
    input  logic        Rxn,
    output logic [15:0] code_word,
    output logic        code_vld,
    output logic        nlp_det,
    output logic        burst_err,
    output logic        link_ok
);

    localparam int unsigned CW = $clog2(CLK_MAX + 1);
    localparam int unsigned LW = $clog2(LINK_TO + 1);
    localparam logic [CW-1:0] DMIN = CW'(DATA_MIN);
    localparam logic [CW-1:0] DMAX = CW'(DATA_MAX);
    localparam logic [CW-1:0] CMIN = CW'(CLK_MIN);
    localparam logic [CW-1:0] CMAX = CW'(CLK_MAX);
    localparam logic [LW-1:0] LTO    = LW'(LINK_TO);
    localparam logic [LW-1:0] LTO_M1 = LW'(LINK_TO - 1);

    logic          pulse;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] ival;
    logic [3:0]    bit_idx;
    logic          got_data;
    logic [14:0]   shreg;
    logic [LW-1:0] link_timer;
    logic          in_data;
    logic          in_clk;
    logic          word_done;
    logic          nlp_done;

    flp_pulse_det #(.PW_MIN(PW_MIN)) u_pulse_det (
        .clk   (clk),
        .reset (reset),
        .rxp   (Rxp),
        .rxn   (Rxn),
        .pulse (pulse)
    );

    // cnt is cleared in the pulse cycle, so the distance to the current cycle is cnt+1.
    assign ival      = cnt + CW'(1);
    assign in_data   = (ival >= DMIN) && (ival <= DMAX);
    assign in_clk    = (ival >= CMIN) && (ival <= CMAX);
    assign word_done = (state == BURST) && pulse && in_clk && (bit_idx == 4'd15);
    assign nlp_done  = (state == BURST) && !pulse && (ival == CMAX)
                       && (bit_idx == 4'd0) && !got_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            got_data   <= 1'b0;
            shreg      <= '0;
            code_word  <= '0;
            code_vld   <= 1'b0;
            nlp_det    <= 1'b0;
            burst_err  <= 1'b0;
            link_ok    <= 1'b0;
            link_timer <= '0;
        end else begin
            code_vld  <= 1'b0;
            nlp_det   <= 1'b0;
            burst_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (pulse) begin
                        state    <= BURST;
                        cnt      <= '0;
                        bit_idx  <= '0;
                        got_data <= 1'b0;
                        shreg    <= '0;
                    end
                end
                BURST: begin
                    if (pulse) begin
                        if (in_clk) begin
                            cnt      <= '0;
                            got_data <= 1'b0;
                            if (bit_idx == 4'd15) begin
                                code_word <= {got_data, shreg};
                                code_vld  <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                // Bits enter at the top so D0 lands in bit 0 after 15 shifts.
                                shreg   <= {got_data, shreg[14:1]};
                                bit_idx <= bit_idx + 4'd1;
                            end
                        end else if (in_data && !got_data) begin
                            got_data <= 1'b1;
                            cnt      <= cnt + CW'(1);
                        end else begin
                            burst_err <= 1'b1;
                            cnt       <= '0;
                            bit_idx   <= '0;
                            got_data  <= 1'b0;
                            shreg     <= '0;
                        end
                    end else if (ival == CMAX) begin
                        if ((bit_idx == 4'd0) && !got_data) begin
                            nlp_det <= 1'b1;
                        end else begin
                            burst_err <= 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // Link monitor: set by a good burst or NLP, cleared as the timer saturates.
            if (pulse) begin
                link_timer <= '0;
            end else if (link_timer != LTO) begin
                link_timer <= link_timer + LW'(1);
            end
            if (word_done || nlp_done) begin
                link_ok <= 1'b1;
            end else if (!pulse && (link_timer >= LTO_M1)) begin
                link_ok <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_flp_rx.sv
// Directed bench for flp_rx with timing scaled down so whole bursts and the
// link timeout fit in a short run.
module tb_flp_rx;

    localparam int PW_MIN   = 5;
    localparam int DATA_MIN = 55;
    localparam int DATA_MAX = 69;
    localparam int CLK_MIN  = 111;
    localparam int CLK_MAX  = 139;
    localparam int LINK_TO  = 5000;
    localparam int NV       = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        Rxp;
    logic        Rxn;
    logic [15:0] code_word;
    logic        code_vld;
    logic        nlp_det;
    logic        burst_err;
    logic        link_ok;

    always #5 clk = ~clk;

    flp_rx #(
        .PW_MIN   (PW_MIN),
        .DATA_MIN (DATA_MIN),
        .DATA_MAX (DATA_MAX),
        .CLK_MIN  (CLK_MIN),
        .CLK_MAX  (CLK_MAX),
        .LINK_TO  (LINK_TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Rxp       (Rxp),
        .Rxn       (Rxn),
        .code_word (code_word),
        .code_vld  (code_vld),
        .nlp_det   (nlp_det),
        .burst_err (burst_err),
        .link_ok   (link_ok)
    );

    typedef struct {
        logic [15:0] word;
        int          period;
        int          nclk;
        int          pw;
        int          dpos;
        int          lead;
        bit          cm;
        int          e_vld;
        int          e_err;
        int          e_nlp;
        logic [15:0] e_word;
        bit          e_link;
    } vec_t;

    vec_t vecs [NV];

    int   cyc = 0;
    int   n_vld = 0, n_nlp = 0, n_err = 0, n_drop = 0;
    int   first_vld_cyc = -1, rise_cyc = -1, nlp_cyc = -1, drop_cyc = -1;
    logic link_prev = 1'b0;
    int   n_chk = 0, n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe and link-edge monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (code_vld === 1'b1) begin
            if (n_vld == 0) first_vld_cyc = cyc;
            n_vld++;
        end
        if (nlp_det === 1'b1) begin
            n_nlp++;
            nlp_cyc = cyc;
        end
        if (burst_err === 1'b1) n_err++;
        if (link_ok === 1'b1 && !link_prev && rise_cyc < 0) rise_cyc = cyc;
        if (link_ok === 1'b0 && link_prev) begin
            n_drop++;
            drop_cyc = cyc;
        end
        link_prev = (link_ok === 1'b1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Clock pulses every 'period' cycles, data pulse at 'dpos' in slot i when word[i];
    // optional lone lead pulse 'lead' cycles before the burst; cm drives both legs.
    task automatic drive(input logic [15:0] word, input int period, input int nclk,
                         input int pw, input int dpos, input int lead, input bit cm);
        int total, b, i, r;
        bit h;
        total = lead + (nclk - 1) * period + pw + 1;
        for (int t = 0; t < total; t++) begin
            h = 1'b0;
            if (lead > 0 && t < pw) h = 1'b1;
            b = t - lead;
            if (b >= 0) begin
                i = b / period;
                r = b % period;
                if (i < nclk && r < pw) h = 1'b1;
                if (i < nclk - 1 && word[i] && r >= dpos && r < dpos + pw) h = 1'b1;
            end
            @(posedge clk);
            #1;
            Rxp = h;
            Rxn = cm ? h : 1'b0;
        end
        Rxp = 1'b0;
        Rxn = 1'b0;
    endtask

    task automatic single_pulse(output int c0);
        @(posedge clk);
        #1;
        c0  = cyc;
        Rxp = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        Rxp = 1'b0;
    endtask

    initial begin
        int b_vld, b_err, b_nlp, b_drop, c0;

        reset = 1'b1;
        Rxp   = 1'b0;
        Rxn   = 1'b0;

        //            word      per  n   pw  dpos lead cm  vld err nlp  e_word    link
        vecs[0]  = '{16'h41E1, 125, 17, 10, 62,  0, 1'b0, 1, 0, 0, 16'h41E1, 1'b1};
        vecs[1]  = '{16'hFFFF, 125, 17,  3, 62,  0, 1'b0, 0, 0, 0, 16'h41E1, 1'b1};
        vecs[2]  = '{16'h0000, 125, 17, 10, 62,  0, 1'b0, 1, 0, 0, 16'h0000, 1'b1};
        vecs[3]  = '{16'hFFFF, 125, 17,  4, 62,  0, 1'b0, 0, 0, 0, 16'h0000, 1'b1};
        vecs[4]  = '{16'h0F0F, 125, 17,  5, 62,  0, 1'b0, 1, 0, 0, 16'h0F0F, 1'b1};
        vecs[5]  = '{16'hFFFF, 125, 17, 10, 62,  0, 1'b1, 0, 0, 0, 16'h0F0F, 1'b1};
        vecs[6]  = '{16'hA5A5, 139, 17, 10, 62,  0, 1'b0, 1, 0, 0, 16'hA5A5, 1'b1};
        vecs[7]  = '{16'h00FF, 125,  9, 10, 62,  0, 1'b0, 0, 1, 0, 16'hA5A5, 1'b1};
        vecs[8]  = '{16'h0000, 140,  3, 10, 62,  0, 1'b0, 0, 0, 3, 16'hA5A5, 1'b1};
        vecs[9]  = '{16'hFFFF, 125, 17, 10, 62, 90, 1'b0, 1, 1, 0, 16'hFFFF, 1'b1};
        vecs[10] = '{16'h0001, 125, 17, 10, 50,  0, 1'b0, 0, 3, 0, 16'hFFFF, 1'b1};
        vecs[11] = '{16'h1234, 111, 17, 10, 62,  0, 1'b0, 1, 0, 0, 16'h1234, 1'b1};

        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset code_word", code_word, 0);
        check("reset code_vld", code_vld, 0);
        check("reset nlp_det", nlp_det, 0);
        check("reset burst_err", burst_err, 0);
        check("reset link_ok", link_ok, 0);

        for (int k = 0; k < NV; k++) begin
            b_vld = n_vld;
            b_err = n_err;
            b_nlp = n_nlp;
            drive(vecs[k].word, vecs[k].period, vecs[k].nclk, vecs[k].pw,
                  vecs[k].dpos, vecs[k].lead, vecs[k].cm);
            idle(200);
            @(negedge clk);
            check($sformatf("v%0d code_vld count", k), n_vld - b_vld, vecs[k].e_vld);
            check($sformatf("v%0d burst_err count", k), n_err - b_err, vecs[k].e_err);
            check($sformatf("v%0d nlp_det count", k), n_nlp - b_nlp, vecs[k].e_nlp);
            check($sformatf("v%0d code_word", k), code_word, vecs[k].e_word);
            check($sformatf("v%0d link_ok", k), link_ok, vecs[k].e_link);
        end
        check("link_ok rises with first code_vld", rise_cyc, first_vld_cyc);

        // Isolated NLP: strobe CLK_MAX+1 cycles after the internal pulse event.
        b_nlp = n_nlp;
        b_err = n_err;
        single_pulse(c0);
        idle(200);
        @(negedge clk);
        check("nlp count", n_nlp - b_nlp, 1);
        check("nlp latency from Rxp edge", nlp_cyc - c0, 2 + PW_MIN + CLK_MAX + 1);
        check("nlp no burst_err", n_err - b_err, 0);
        check("nlp code_word held", code_word, 16'h1234);
        check("nlp link_ok", link_ok, 1);

        // Reset just after bit 7 closes; the partial word must vanish silently.
        drive(16'hFFFF, 125, 9, 10, 62, 0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midreset code_word", code_word, 0);
        check("midreset link_ok", link_ok, 0);
        check("midreset strobes", {code_vld, nlp_det, burst_err}, 0);
        b_vld = n_vld;
        b_err = n_err;
        b_nlp = n_nlp;
        idle(300);
        @(negedge clk);
        check("midreset later strobes", (n_vld - b_vld) + (n_err - b_err) + (n_nlp - b_nlp), 0);
        drive(16'hC3A5, 125, 17, 10, 62, 0, 1'b0);
        idle(200);
        @(negedge clk);
        check("post-reset code_vld count", n_vld - b_vld, 1);
        check("post-reset code_word", code_word, 16'hC3A5);
        check("post-reset burst_err", n_err - b_err, 0);

        // Keep-alive pulses every 1600 cycles, then silence until link loss.
        b_drop = n_drop;
        for (int p = 0; p < 4; p++) begin
            single_pulse(c0);
            idle(1590);
        end
        @(negedge clk);
        check("keepalive no link drop", n_drop - b_drop, 0);
        check("keepalive link_ok", link_ok, 1);
        idle(4000);
        @(negedge clk);
        check("link loss drop count", n_drop - b_drop, 1);
        check("link loss timing", drop_cyc - c0, 2 + PW_MIN + 1 + LINK_TO);
        check("link loss link_ok", link_ok, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/flp_rx.md
# flp_rx

Receive-side counterpart of the fast link pulse generator in the 10BASE-T PHY. Watches the differential receive pair for link pulses and classifies each burst as a normal link pulse (NLP) or a fast link pulse (FLP) burst. For a valid FLP burst it decodes the 16-bit link code word. Maintains a link-integrity flag for the autonegotiation / link-monitor logic.

## Interface
- `PW_MIN`, 5: minimum qualified pulse width in clk cycles (50 ns at 100 MHz).
- `DATA_MIN`, 5550: earliest data-pulse position after a clock pulse, in cycles (55.5 µs).
- `DATA_MAX`, 6950: latest data-pulse position, in cycles (69.5 µs).
- `CLK_MIN`, 11100: earliest next clock-pulse position, in cycles (111 µs).
- `CLK_MAX`, 13900: latest next clock-pulse position, in cycles (139 µs).
- `LINK_TO`, 5000000: link-loss timeout, in cycles (50 ms).
- `clk`  in  1  system clock, 100 MHz nominal.
- `reset`  in  1  synchronous, active-high reset.
- `Rxp`  in  1  receive pair, positive leg; asynchronous to clk.
- `Rxn`  in  1  receive pair, negative leg; asynchronous to clk.
- `code_word`  out  16  last decoded link code word; D0 is the LSB.
- `code_vld`  out  1  one-cycle strobe; `code_word` was updated.
- `nlp_det`  out  1  one-cycle strobe; an isolated NLP was detected.
- `burst_err`  out  1  one-cycle strobe; a burst was malformed.
- `link_ok`  out  1  link-integrity flag.

## Operation
- **Input conditioning**
  - Two-flop synchronizer on `Rxp` and on `Rxn`.
  - `hi` = `Rxp_s & ~Rxn_s`.
  - A run counter counts consecutive `hi` cycles and saturates at `PW_MIN`.
  - `pulse` is a one-cycle event generated in the cycle the run count reaches `PW_MIN`; at most one event per pulse.
  - Runs shorter than `PW_MIN` are ignored.
- **Interval counter `cnt`**
  - Cleared on every accepted clock pulse.
  - Increments in BURST state.
  - Width is `$clog2(CLK_MAX+1)`.
- **FSM states**
  - IDLE: on `pulse` → BURST, with `cnt`=0, `bit_idx`=0, `got_data`=0, shift register cleared.
  - BURST, `pulse` with `DATA_MIN` ≤ `cnt` ≤ `DATA_MAX` and `got_data`=0: set `got_data`=1.
  - BURST, `pulse` with `CLK_MIN` ≤ `cnt` ≤ `CLK_MAX`:
    - Shift `got_data` into bit `bit_idx`, then set `cnt`=0, `got_data`=0, `bit_idx`++.
    - If this closes bit 15 (17th clock pulse): load `code_word`, pulse `code_vld`, → IDLE.
  - BURST, `pulse` at any other `cnt` (including a second pulse in the data window): pulse `burst_err`, then treat this pulse as the first clock pulse of a new burst (stay in BURST, reinitialise as from IDLE).
  - BURST, `cnt` = `CLK_MAX` with no pulse in that cycle:
    - If `bit_idx`=0 and `got_data`=0: pulse `nlp_det`.
    - Otherwise: pulse `burst_err`.
    - Either way → IDLE.
- **Link monitor**
  - A timer clears on every `pulse` and saturates at `LINK_TO`.
  - `link_ok` is set by `code_vld` or `nlp_det`.
  - `link_ok` clears when the timer reaches `LINK_TO`.
  - If set and clear occur in the same cycle, set wins.
- `code_word` holds its value until the next valid burst; an error never modifies it.

## Timing
- **Reset values:** all outputs 0, including `code_word`=0 and `link_ok`=0; FSM in IDLE; all counters 0.
- **Reset mid-burst:** the partial word is discarded and no strobe is issued.
- **Pulse latency:** `pulse` occurs 2 + `PW_MIN` cycles after the `Rxp` rising edge. The latency is identical for every pulse, so intervals are measured exactly.
- **Strobe timing:** `code_vld`, `nlp_det` and `burst_err` are registered; each is high exactly 1 cycle, in the cycle after the deciding event.
- **Window boundaries:** inclusive at both ends. A `pulse` in the same cycle `cnt` reaches `CLK_MAX` counts as an accepted clock pulse; the timeout does not fire.
- **`bit_idx`:** 4 bits plus a terminal condition; no wrap-around beyond 16 bits.

## Structure
- **Package `flp_pkg`:**
  - Timing constants DATA/CLK windows and `LINK_TO`, shared with the FLP transmitter.
  - FSM state enum (IDLE, BURST).
  - Code-word field typedef: selector[4:0], ability[12:5], RF, Ack, NP.
- **Sub-module `flp_pulse_det`:** synchronizer plus run-length qualifier; outputs `pulse`.
- **`flp_rx` itself:** FSM, interval counter, shift register and link timer.

## Test plan
- **Valid FLP:** reset, then an FLP burst encoding 0x41E1 (clock pulses 125 µs apart, data pulses at 62.5 µs, 100 ns wide) → a single `code_vld` with `code_word`=0x41E1; `link_ok` rises in the same cycle as `code_vld`; no `burst_err`.
- **Isolated NLP:** a single 100 ns pulse, then silence → `nlp_det` exactly `CLK_MAX`+1 cycles after `pulse`; `link_ok`=1; `code_word` stays 0.
- **Glitch rejection and window edges:**
  - A 30 ns pulse produces no `pulse`.
  - A clock pulse at `cnt`=`CLK_MAX` is accepted.
  - A clock pulse at `cnt`=`CLK_MAX`+1 causes timeout then a restart.
- **Malformed burst:**
  - A pulse at 90 µs after a clock pulse → `burst_err`, then the next 17-pulse burst of 0xFFFF decodes correctly.
  - Truncation after 8 bits → `burst_err`, and `code_word` is unchanged.
- **Link loss:** after `link_ok`=1, no pulses for `LINK_TO` cycles → `link_ok`=0 exactly when the timer saturates; with pulses every 16 ms, `link_ok` stays 1.
- **Reset mid-burst:** assert `reset` for 1 cycle after bit 7 → all outputs 0, no strobes, FSM in IDLE; a subsequent full burst decodes.
